request_encoder: RTL



---
 rtl/uart_bus_pkg.sv | 17 +
 rtl/request_encoder_rr_pick.sv | 33 +++
 rtl/request_encoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART bus initiator and its address decoder.
//   ADDR_W / NUM_REQ : address width and number of decoded peripherals
//   state_t          : request_encoder FSM states
//   DEFAULT_MAX_HOLD : default grant hold limit, in cycles, before forced release
package uart_bus_pkg;

   localparam int ADDR_W           = 3;
   localparam int NUM_REQ          = 2 ** ADDR_W;
   localparam int DEFAULT_MAX_HOLD = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/request_encoder_rr_pick.sv
// Combinational round-robin search.
//   eligible : request lines that may be granted
//   last_ptr : most recently served index, which gets the lowest priority
//   found    : at least one eligible line exists
//   index    : first eligible index after last_ptr, wrapping modulo NUM_REQ
module rr_pick
   import uart_bus_pkg::*;
(
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [ADDR_W-1:0]  last_ptr,
   output logic               found,
   output logic [ADDR_W-1:0]  index
);

   logic [ADDR_W-1:0] cand;

   // Walk from the farthest offset down to the nearest, so the nearest hit
   // after last_ptr is the one that survives. Offset NUM_REQ wraps back to
   // last_ptr itself and is therefore the last resort.
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = last_ptr + ADDR_W'(i);
         if (eligible[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/request_encoder.sv
// Round-robin request encoder: selects one of NUM_REQ peripheral requests and
// drives its address plus an enable into the UART address decoder. Each grant
// is held until done or a hold timeout, followed by a one-cycle release gap.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   req          : per-peripheral request levels
//   mask         : 1 = ignore the matching req bit
//   done         : granted peripheral finished (only looked at in GRANT)
//   address_out  : granted index to the decoder
//   enable_out   : decoder enable, high only in GRANT
//   grant_onehot : one-hot form of the grant, zero when enable_out is low
//   busy         : high in GRANT and RELEASE
//   timeout      : one-cycle pulse when a grant is force-released
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant; pick the next eligible line round-robin
// GRANT   | decoder enabled for address_out; wait for done or hold limit
// RELEASE | one enable-low gap cycle so decoder selects never overlap
module request_encoder
   import uart_bus_pkg::*;
#(
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
   parameter int CNT_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic               done,
   output logic [ADDR_W-1:0]  address_out,
   output logic               enable_out,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic               busy,
   output logic               timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t             state;
   logic [CNT_W-1:0]   hold_cnt;
   logic [ADDR_W-1:0]  last_ptr;
   logic [NUM_REQ-1:0] eligible;
   logic               pick_found;
   logic [ADDR_W-1:0]  pick_idx;

   assign eligible = req & ~mask;

   rr_pick u_rr_pick (
      .eligible (eligible),
      .last_ptr (last_ptr),
      .found    (pick_found),
      .index    (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         address_out  <= '0;
         enable_out   <= 1'b0;
         grant_onehot <= '0;
         busy         <= 1'b0;
         timeout      <= 1'b0;
         hold_cnt     <= '0;
         last_ptr     <= ADDR_W'(NUM_REQ - 1);
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               enable_out   <= 1'b0;
               grant_onehot <= '0;
               busy         <= 1'b0;
               hold_cnt     <= '0;
               if (pick_found) begin
                  state        <= GRANT;
                  address_out  <= pick_idx;
                  enable_out   <= 1'b1;
                  grant_onehot <= NUM_REQ'(1) << pick_idx;
                  busy         <= 1'b1;
               end
            end

            GRANT: begin
               // done takes precedence over the hold limit, so a release on
               // the last allowed cycle with done present is not a timeout.
               if (done || (hold_cnt == HOLD_LAST)) begin
                  state        <= RELEASE;
                  enable_out   <= 1'b0;
                  grant_onehot <= '0;
                  hold_cnt     <= '0;
                  last_ptr     <= address_out;
                  timeout      <= ~done;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            RELEASE: begin
               state        <= IDLE;
               enable_out   <= 1'b0;
               grant_onehot <= '0;
               busy         <= 1'b0;
               hold_cnt     <= '0;
            end

            default: begin
               state        <= IDLE;
               address_out  <= '0;
               enable_out   <= 1'b0;
               grant_onehot <= '0;
               busy         <= 1'b0;
               hold_cnt     <= '0;
            end
         endcase
      end
   end

endmodule
